oven_key_conditioner: RTL

Upstream front end for the oven controller. It takes the four raw, active-low board pushbuttons: A (display/on), B (temp up), C (temp down) and D (start). For each key it synchronises the input, debounces it and edge-detects it. Its outputs are clean pressed levels, one-cycle press and release pulses, and an auto-repeating step pulse. The controller consumes these instead of sampling the keys directly, so one press changes the target temperature by exactly one step, and holding B or C steps it repeatedly.

---
 rtl/oven_pkg.sv | 11 +
 rtl/oven_key_conditioner_if.sv | 12 +
 rtl/oven_key_channel.sv | 77 +++++++
 rtl/oven_key_conditioner.sv | 34 +++
 4 files changed

// File: rtl/oven_pkg.sv
// oven_pkg: key indices, repeat-state encoding and the ms-to-cycles helper shared by the key front end.
package oven_pkg;
  localparam int KEY_A = 0;
  localparam int KEY_B = 1;
  localparam int KEY_C = 2;
  localparam int KEY_D = 3;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  function automatic int ms_to_cyc(int clk_hz, int ms);
    return clk_hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/oven_key_conditioner_if.sv
// oven_key_conditioner_if: raw active-low keys in, conditioned levels and pulses out.
interface oven_key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] step;
  modport master (output key_n, input level, press, release_pulse, step);
  modport slave (input key_n, output level, press, release_pulse, step);
endinterface

// File: rtl/oven_key_channel.sv
// oven_key_channel: one key - 2-flop sync, debounce, press/release pulses, auto-repeat step.
// Repeat FSM is built only when KEY_AUTOREPEAT_EN is defined; otherwise step mirrors press.
module oven_key_channel
  import oven_pkg::*;
#(
  parameter int DB_CYC = 1,
  parameter int DLY_CYC = 1,
  parameter int RATE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic step
);
  if (DB_CYC < 1 || DLY_CYC < 1 || RATE_CYC < 1) begin : g_bad_cfg
    $error("oven_key_channel: every derived cycle count must be at least 1");
  end
  localparam int DBW = $clog2(DB_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
  logic [1:0] sync;
  logic [DBW-1:0] cnt;
  logic flip;
  logic rise;
  logic level_next;
  assign flip = sync[1] != level && cnt == DB_LAST;
  assign rise = flip && !level;
  assign level_next = level ^ flip;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync <= {sync[0], ~key_n};
      cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= level_next;
      press <= rise;
      release_pulse <= flip && level;
    end
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int TW = $clog2((DLY_CYC > RATE_CYC ? DLY_CYC : RATE_CYC) + 1);
  rpt_state_t state;
  rpt_state_t state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic step_next;
  logic expire;
  // timer == 1 means it reaches zero on this edge, so the registered step lands exactly on the period
  assign expire = state != IDLE && timer == TW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      step <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      step <= step_next;
    end
  end
  always_comb begin
    state_next = !level_next ? IDLE : rise ? DELAY : expire ? REPEAT : state;
  end
  always_comb begin
    step_next = rise || (expire && level_next);
    timer_next = rise ? TW'(DLY_CYC) : expire ? TW'(RATE_CYC) : state == IDLE ? TW'(0) : timer - 1'b1;
  end
`else
  assign step = press;
`endif
endmodule

// File: rtl/oven_key_conditioner.sv
// oven_key_conditioner: N_KEYS independent key channels for the oven controller.
// Auto-repeat on step is built only when KEY_AUTOREPEAT_EN is defined.
module oven_key_conditioner
  import oven_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS = 100,
  parameter int N_KEYS = 4
) (
  input logic clk,
  input logic rst,
  oven_key_conditioner_if.slave keys
);
  localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int DLY_CYC = ms_to_cyc(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RATE_CYC = ms_to_cyc(CLK_HZ, REPEAT_RATE_MS);
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    oven_key_channel #(
      .DB_CYC(DB_CYC),
      .DLY_CYC(DLY_CYC),
      .RATE_CYC(RATE_CYC)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key_n(keys.key_n[k]),
      .level(keys.level[k]),
      .press(keys.press[k]),
      .release_pulse(keys.release_pulse[k]),
      .step(keys.step[k])
    );
  end
endmodule
